// File: rtl/param_register_file.sv
// Two-read/one-write register file with a sequential clear engine (IDLE/CLEAR/DONE).
// Optional macro REGFILE_BYPASS_EN forwards an accepted same-cycle write to matching read ports.
module param_register_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   idx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_acc;

  assign clear_busy = (state == CLEAR);
  assign clear_done = (state == DONE);
  assign wr_acc     = RegWrite && !clear_busy && !((ZERO_REG != 0) && (write_addr == '0));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx is held at 0 while idle so a clear always begins at register 0;
  // the extra bit lets it reach DEPTH in DONE without wrapping back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE)       idx <= '0;
      else if (state == CLEAR) idx <= idx + (ADDR_W + 1)'(1);

      if (state == CLEAR)  regs[idx[ADDR_W-1:0]] <= '0;
      else if (wr_acc)     regs[write_addr]      <= write_data;
    end
  end

  always_comb begin
    read_data1 = regs[read_addr1];
    read_data2 = regs[read_addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc && (write_addr == read_addr1)) read_data1 = write_data;
    if (wr_acc && (write_addr == read_addr2)) read_data2 = write_data;
`endif
    if ((ZERO_REG != 0) && (read_addr1 == '0)) read_data1 = '0;
    if ((ZERO_REG != 0) && (read_addr2 == '0)) read_data2 = '0;
  end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter DATA_W, default 8, data width of each register.
REQ-002 Parameter ADDR_W, default 2, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-006 RegWrite  input  1  write request for current cycle.
REQ-007 write_addr  input  ADDR_W  write target register.
REQ-008 write_data  input  DATA_W  write value.
REQ-009 read_addr1  input  ADDR_W  port-1 read address.
REQ-010 read_addr2  input  ADDR_W  port-2 read address.
REQ-011 read_data1  output  DATA_W  port-1 read data, combinational.
REQ-012 read_data2  output  DATA_W  port-2 read data, combinational.
REQ-013 clear_req  input  1  request to zero whole file, sampled in IDLE only.
REQ-014 clear_busy  output  1  high while clear sequence in progress.
REQ-015 clear_done  output  1  one-cycle pulse on clear completion.

Function
REQ-016 Write accepted = RegWrite & ~clear_busy; accepted write updates register write_addr at that rising edge.
REQ-017 RegWrite while clear_busy=1 SHALL be dropped silently; no queuing.
REQ-018 ZERO_REG=1: writes to address 0 ignored; reads of address 0 return 0 on both ports.
REQ-019 Reads: read_dataN = contents[read_addrN], no clock latency; both ports independent, same address allowed.
REQ-020 Clear FSM states IDLE, CLEAR, DONE; IDLE→CLEAR when clear_req=1 in IDLE.
REQ-021 CLEAR: internal index starts 0, zeroes register[index] each cycle, increments by 1; clear_busy=1.
REQ-022 CLEAR→DONE after index DEPTH-1 zeroed; busy duration exactly DEPTH cycles.
REQ-023 DONE: clear_done=1, clear_busy=0 for one cycle, then →IDLE unconditionally; writes accepted in DONE.
REQ-024 clear_req in CLEAR or DONE ignored; held clear_req re-triggers from IDLE on next IDLE cycle.
REQ-025 RegWrite and clear_req together in IDLE: write performed that edge, clear starts; written register later zeroed.
REQ-026 Reads during CLEAR return current contents (already-cleared entries read 0, others retain value).
REQ-027 Index counter ADDR_W+1 bits wide; no wrap past DEPTH-1.

Reset
REQ-028 reset=0 at rising edge: all registers 0, FSM IDLE, index 0, clear_busy=0, clear_done=0.
REQ-029 reset=0 takes priority over RegWrite and clear FSM, including mid-CLEAR (sequence aborted).
REQ-030 After reset, read_data1/read_data2 = 0 for all addresses until written.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: read port returns write_data when accepted write in same cycle targets its read_addr (not address 0 with ZERO_REG=1).
REQ-032 REGFILE_BYPASS_EN undefined: read ports return stored value only; new data visible the cycle after the write edge.

Verification
REQ-033 Reset low one edge, then read all 4 addresses both ports → all 0x00, clear_busy=0.
REQ-034 Write 0xA5 to r2, 0x3C to r3; read_addr1=2, read_addr2=3 → 0xA5, 0x3C next cycle; same-cycle 0xA5/0x3C only with REGFILE_BYPASS_EN.
REQ-035 Load r0..r3 = 0x11,0x22,0x33,0x44; pulse clear_req → clear_busy high exactly 4 cycles, clear_done one pulse, all reads 0x00; RegWrite 0xFF to r1 during busy → r1 stays 0x00.
REQ-036 ZERO_REG=1: write 0x77 to r0 → read_data1 at addr 0 = 0x00; write 0x77 to r1 → 0x77.
REQ-037 Start clear with r3=0x44, assert reset low after 2 busy cycles → r3=0x00, FSM IDLE, clear_done never pulses.
REQ-038 DATA_W=16, ADDR_W=3: write 0xBEEF to r7, clear → clear_busy 8 cycles, r7 reads 0x0000.
